// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the L1-to-main-memory path.
// Block geometry, address and request encodings.
package mem_ctrl_pkg;

    localparam int BLOCK_SIZE_BYTES = 8;
    localparam int ADDR_W           = 32;
    localparam int BLK_ADDR_W       = 16;

    typedef logic [ADDR_W-1:0]             addr_t;
    typedef logic [BLK_ADDR_W-1:0]         main_mem_block_addr_t;
    typedef logic [BLOCK_SIZE_BYTES*8-1:0] block_data_t;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_t;

    typedef enum logic [1:0] {
        BYTE     = 2'd0,
        HALFWORD = 2'd1,
        WORD     = 2'd2
    } req_width_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// Cache-side request/response bundle of the memory controller.
// master = the two L1 caches, slave = mem_ctrl.
import mem_ctrl_pkg::*;

interface mem_ctrl_if;

    logic                 icache_req_valid;
    main_mem_block_addr_t icache_req_block_addr;
    logic                 icache_req_ready;
    logic                 icache_resp_valid;
    block_data_t          icache_resp_block_data;

    logic                 dcache_req_valid;
    req_type_t            dcache_req_type;
    main_mem_block_addr_t dcache_req_block_addr;
    block_data_t          dcache_req_block_data;
    req_width_t           dcache_req_width;
    addr_t                dcache_req_addr;
    logic                 dcache_req_writethrough;
    logic                 dcache_req_ready;
    logic                 dcache_resp_valid;
    block_data_t          dcache_resp_block_data;

    modport master (
        output icache_req_valid,
        output icache_req_block_addr,
        input  icache_req_ready,
        input  icache_resp_valid,
        input  icache_resp_block_data,
        output dcache_req_valid,
        output dcache_req_type,
        output dcache_req_block_addr,
        output dcache_req_block_data,
        output dcache_req_width,
        output dcache_req_addr,
        output dcache_req_writethrough,
        input  dcache_req_ready,
        input  dcache_resp_valid,
        input  dcache_resp_block_data
    );

    modport slave (
        input  icache_req_valid,
        input  icache_req_block_addr,
        output icache_req_ready,
        output icache_resp_valid,
        output icache_resp_block_data,
        input  dcache_req_valid,
        input  dcache_req_type,
        input  dcache_req_block_addr,
        input  dcache_req_block_data,
        input  dcache_req_width,
        input  dcache_req_addr,
        input  dcache_req_writethrough,
        output dcache_req_ready,
        output dcache_resp_valid,
        output dcache_resp_block_data
    );

endinterface

// File: rtl/main_mem.sv
// Block-wide backing store: synchronous read, byte-enabled write.
// A same-edge read of the written block returns the merged new bytes.
import mem_ctrl_pkg::*;

module main_mem #(
    parameter int    N_BLOCKS    = 1024,
    parameter int    BLOCK_BYTES = BLOCK_SIZE_BYTES,
    parameter string INIT_FILE   = "",
    localparam int   IDX_W       = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1
) (
    input  logic                   clk,
    input  logic                   i_rd_en,
    input  logic [IDX_W-1:0]       i_rd_idx,
    output block_data_t            o_rd_data,
    input  logic [BLOCK_BYTES-1:0] i_wr_be,
    input  logic [IDX_W-1:0]       i_wr_idx,
    input  block_data_t            i_wr_data
);

    block_data_t r_mem [N_BLOCKS];
    block_data_t r_rd_data;

    always_ff @(posedge clk) begin
        for (int b = 0; b < BLOCK_BYTES; b++) begin
            if (i_wr_be[b]) begin
                r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
            end
        end
        if (i_rd_en) begin
            for (int b = 0; b < BLOCK_BYTES; b++) begin
                if (i_wr_be[b] && (i_wr_idx == i_rd_idx)) begin
                    r_rd_data[b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end else begin
                    r_rd_data[b*8 +: 8] <= r_mem[i_rd_idx][b*8 +: 8];
                end
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mem_ctrl.sv
// Main-memory controller: icache-priority arbitration, one access
// in flight, fixed latency, one-cycle response pulse to the owner.
import mem_ctrl_pkg::*;

module mem_ctrl #(
    parameter int    MEM_LATENCY = 4,
    parameter int    N_BLOCKS    = 1024,
    parameter int    BLOCK_BYTES = BLOCK_SIZE_BYTES,
    parameter string INIT_FILE   = ""
) (
    input logic       clk,
    input logic       rst_aL,
    mem_ctrl_if.slave bus
);

    localparam int IDX_W = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    typedef logic [BLOCK_BYTES-1:0] be_t;
    typedef logic [IDX_W-1:0]       idx_t;

    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic             r_own_d, w_own_d_n;
    idx_t             r_idx, w_idx_n;
    block_data_t      r_resp_i, r_resp_d;

    logic             w_idle, w_acc_i, w_acc_d;
    idx_t             w_req_idx, w_rd_idx;
    logic [OFF_W-1:0] w_off;
    be_t              w_wt_mask, w_wr_be;
    logic             w_rd_en;
    block_data_t      w_rd_data;
    logic             w_unused;

    assign w_idle  = (r_state == S_IDLE);
    assign w_acc_i = bus.icache_req_valid & w_idle;
    assign w_acc_d = bus.dcache_req_valid & w_idle & ~bus.icache_req_valid;

    assign bus.icache_req_ready = w_idle;
    assign bus.dcache_req_ready = w_idle & ~bus.icache_req_valid;

    // Out-of-range block addresses wrap onto the physical array.
    assign w_req_idx = bus.icache_req_valid
        ? idx_t'(bus.icache_req_block_addr % N_BLOCKS)
        : idx_t'(bus.dcache_req_block_addr % N_BLOCKS);

    assign w_off    = bus.dcache_req_addr[OFF_W-1:0];
    assign w_unused = &{1'b0, bus.dcache_req_addr[ADDR_W-1:OFF_W]};

    always_comb begin
        w_wt_mask = '0;
        unique case (1'b1)
            (bus.dcache_req_width == BYTE):
                w_wt_mask = be_t'(1) << w_off;
            (bus.dcache_req_width == HALFWORD):
                w_wt_mask = be_t'(3) << {w_off[OFF_W-1:1], 1'b0};
            (bus.dcache_req_width == WORD):
                w_wt_mask = be_t'(15) << {w_off[OFF_W-1:2], 2'b00};
            default:
                w_wt_mask = '0;
        endcase
    end

    always_comb begin
        w_state_n             = r_state;
        w_cnt_n               = r_cnt;
        w_own_d_n             = r_own_d;
        w_idx_n               = r_idx;
        w_rd_en               = 1'b0;
        w_rd_idx              = r_idx;
        w_wr_be               = '0;
        bus.icache_resp_valid = 1'b0;
        bus.dcache_resp_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc_i | w_acc_d) begin
                    w_own_d_n = w_acc_d;
                    w_idx_n   = w_req_idx;
                    if (w_acc_d && bus.dcache_req_type == REQ_WRITE) begin
                        w_wr_be = bus.dcache_req_writethrough
                            ? w_wt_mask : '1;
                    end
                    if (MEM_LATENCY == 1) begin
                        w_state_n = S_RESP;
                        w_cnt_n   = '0;
                        w_rd_en   = 1'b1;
                        w_rd_idx  = w_req_idx;
                    end else begin
                        w_state_n = S_BUSY;
                        w_cnt_n   = CNT_W'(MEM_LATENCY - 1);
                    end
                end
            end
            S_BUSY: begin
                w_cnt_n = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_rd_en   = 1'b1;
                    w_state_n = S_RESP;
                end
            end
            S_RESP: begin
                bus.icache_resp_valid = ~r_own_d;
                bus.dcache_resp_valid = r_own_d;
                w_state_n             = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_own_d  <= 1'b0;
            r_idx    <= '0;
            r_resp_i <= '0;
            r_resp_d <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_own_d <= w_own_d_n;
            r_idx   <= w_idx_n;
            if (r_state == S_RESP) begin
                if (r_own_d) r_resp_d <= w_rd_data;
                else         r_resp_i <= w_rd_data;
            end
        end
    end

    // During RESP the fresh read data is presented directly.
    assign bus.icache_resp_block_data =
        (r_state == S_RESP && !r_own_d) ? w_rd_data : r_resp_i;
    assign bus.dcache_resp_block_data =
        (r_state == S_RESP && r_own_d) ? w_rd_data : r_resp_d;

    main_mem #(
        .N_BLOCKS    (N_BLOCKS),
        .BLOCK_BYTES (BLOCK_BYTES),
        .INIT_FILE   (INIT_FILE)
    ) u_main_mem (
        .clk       (clk),
        .i_rd_en   (w_rd_en),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data),
        .i_wr_be   (w_wr_be & {BLOCK_BYTES{rst_aL}}),
        .i_wr_idx  (w_req_idx),
        .i_wr_data (bus.dcache_req_block_data)
    );

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized bench for mem_ctrl at latencies 4 and 1 against a
// transaction-level model of memory contents and response timing.
import mem_ctrl_pkg::*;

module tb_mem_ctrl;

    localparam int NB   = 16;
    localparam int BB   = BLOCK_SIZE_BYTES;
    localparam int NCYC = 1500;

    logic clk = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic block_data_t merge(input block_data_t old,
                                          input block_data_t wd,
                                          input bit wt, input int wid,
                                          input int off);
        block_data_t r;
        int          len;
        int          start;
        if (!wt) return wd;
        r     = old;
        len   = (wid == 0) ? 1 : (wid == 1) ? 2 : 4;
        start = (off / len) * len;
        for (int b = 0; b < BB; b++) begin
            if (b >= start && b < start + len) r[b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic main_mem_block_addr_t rnd_blk();
        int v;
        v = $urandom_range(0, 7) + NB * $urandom_range(0, 3);
        return main_mem_block_addr_t'(v);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 4 : 1;

        mem_ctrl_if bus ();
        logic       rst_aL;
        bit         fin = 1'b0;

        mem_ctrl #(
            .MEM_LATENCY (LAT),
            .N_BLOCKS    (NB),
            .BLOCK_BYTES (BB),
            .INIT_FILE   ("")
        ) u_dut (
            .clk    (clk),
            .rst_aL (rst_aL),
            .bus    (bus)
        );

        initial begin
            block_data_t          mm [NB];
            block_data_t          rdata, exp_i, exp_d, dd;
            int                   cyc, due, n_init, idx, dw;
            bit                   pend, own_d, in_rst, ip, dp;
            bit                   dinit, dwr, dwt;
            main_mem_block_addr_t ia, da;
            addr_t                dadr;
            string                p;

            p      = $sformatf("L%0d", LAT);
            cyc    = 0;
            due    = 0;
            n_init = 0;
            pend   = 0;
            own_d  = 0;
            ip     = 0;
            dp     = 0;
            dinit  = 0;
            dwr    = 0;
            dwt    = 0;
            dw     = 0;
            ia     = '0;
            da     = '0;
            dd     = '0;
            dadr   = '0;
            rdata  = '0;
            exp_i  = '0;
            exp_d  = '0;
            in_rst = 1;
            rst_aL = 1'b0;
            bus.icache_req_valid        = 1'b0;
            bus.icache_req_block_addr   = '0;
            bus.dcache_req_valid        = 1'b0;
            bus.dcache_req_type         = REQ_READ;
            bus.dcache_req_block_addr   = '0;
            bus.dcache_req_block_data   = '0;
            bus.dcache_req_width        = BYTE;
            bus.dcache_req_addr         = '0;
            bus.dcache_req_writethrough = 1'b0;

            repeat (NCYC) begin
                @(negedge clk);
                if (pend && cyc > due) pend = 0;
                if (pend && cyc == due) begin
                    if (own_d) exp_d = rdata;
                    else       exp_i = rdata;
                end
                check({p, "_i_resp_valid"}, 64'(bus.icache_resp_valid),
                      64'(pend && cyc == due && !own_d));
                check({p, "_d_resp_valid"}, 64'(bus.dcache_resp_valid),
                      64'(pend && cyc == due && own_d));
                check({p, "_i_ready"}, 64'(bus.icache_req_ready),
                      64'(!pend));
                check({p, "_d_ready"}, 64'(bus.dcache_req_ready),
                      64'(!pend && !ip));
                check({p, "_i_data"}, bus.icache_resp_block_data, exp_i);
                check({p, "_d_data"}, bus.dcache_resp_block_data, exp_d);

                if (in_rst) begin
                    rst_aL = 1'b1;
                    in_rst = 0;
                end else if (pend && $urandom_range(0, 60) == 0) begin
                    rst_aL = 1'b0;
                    in_rst = 1;
                    pend   = 0;
                    exp_i  = '0;
                    exp_d  = '0;
                    ip     = 0;
                    dp     = 0;
                    bus.icache_req_valid = 1'b0;
                    bus.dcache_req_valid = 1'b0;
                end else if (!pend && ip) begin
                    pend  = 1;
                    own_d = 0;
                    due   = cyc + LAT;
                    ip    = 0;
                    rdata = mm[ia % NB];
                end else if (!pend && dp) begin
                    pend  = 1;
                    own_d = 1;
                    due   = cyc + LAT;
                    dp    = 0;
                    idx   = int'(da % NB);
                    if (dwr) begin
                        mm[idx] = merge(mm[idx], dd, dwt, dw,
                                        int'(dadr % BB));
                    end
                    rdata = mm[idx];
                    if (dinit) n_init++;
                end

                @(posedge clk);
                cyc++;
                #1;
                if (!in_rst) begin
                    if (!ip && n_init >= 8 && $urandom_range(0, 3) == 0) begin
                        ip = 1;
                        ia = rnd_blk();
                    end
                    if (!dp && $urandom_range(0, 2) == 0) begin
                        dp    = 1;
                        dinit = (n_init < 8);
                        dd    = block_data_t'({$urandom, $urandom});
                        dadr  = addr_t'($urandom);
                        if (dinit) begin
                            da  = main_mem_block_addr_t'(n_init);
                            dwr = 1;
                            dwt = 0;
                            dw  = 2;
                        end else begin
                            da  = rnd_blk();
                            dwr = 1'($urandom_range(0, 1));
                            dwt = 1'($urandom_range(0, 1));
                            dw  = $urandom_range(0, 2);
                        end
                    end
                    bus.icache_req_valid        = ip;
                    bus.icache_req_block_addr   = ia;
                    bus.dcache_req_valid        = dp;
                    bus.dcache_req_type         = dwr ? REQ_WRITE : REQ_READ;
                    bus.dcache_req_block_addr   = da;
                    bus.dcache_req_block_data   = dd;
                    bus.dcache_req_width        = req_width_t'(dw);
                    bus.dcache_req_addr         = dadr;
                    bus.dcache_req_writethrough = dwt;
                end
            end
            fin = 1'b1;
        end

        // Response pulses are exclusive between the two caches.
        always @(negedge clk) begin
            if (rst_aL === 1'b1 &&
                bus.icache_resp_valid && bus.dcache_resp_valid) begin
                check("both_resp_valid", 64'd1, 64'd0);
            end
        end
    end

    initial begin
        for (int k = 0; k < NCYC + 200; k++) begin
            if (g_inst[0].fin && g_inst[1].fin) break;
            @(posedge clk);
        end
        check("finish", 64'(g_inst[0].fin && g_inst[1].fin), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
